qpu_exu_longp_wbck_arb: RTL and testbench

- Arbitrates long-pipe write-back between two sources: the LSU (classical loads) and the MCU (quantum measurement results).
- Retires strictly in OITF order. A source is granted only when its itag equals the itag of the oldest OITF entry.
- Registers the granted result in a one-entry output stage that feeds the final write-back module.
- Also provides a pending-destination indication for the dependency check, and a sticky stall watchdog error.

---
 rtl/qpu_exu_longp_wbck_arb_pkg.sv | 18 +
 rtl/qpu_exu_longp_wbck_arb_obuf.sv | 45 ++++
 rtl/qpu_exu_longp_wbck_arb.sv | 125 ++++++++++++
 tb/tb_qpu_exu_longp_wbck_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_exu_longp_wbck_arb_pkg.sv
// Shared constants for the long-pipe write-back arbiter.
//   - Datapath widths (XLEN, RF index width, OITF itag width).
//   - Source indices: LSU is 0 and MCU is 1. LSU wins any tie.
//   - Width of the stall watchdog counter.
package qpu_exu_longp_wbck_arb_pkg;

    localparam int QPU_XLEN    = 32;
    localparam int QPU_RFIDX_W = 5;
    localparam int QPU_ITAG_W  = 2;

    localparam int WDOG_W = 16;

    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_MCU = 1'b1
    } src_e;

endpackage

// File: rtl/qpu_exu_longp_wbck_arb_obuf.sv
// qpu_wbck_obuf: one-entry valid/ready pipeline register for write-back results.
//   clk, rst_n     : clock and synchronous active-low reset
//   in_valid       : capture request. The caller asserts it only when in_ready is high.
//   in_ready       : the entry is free, or it drains in this cycle
//   in_data/rdidx  : result and destination to capture
//   out_valid      : the entry holds a result
//   out_ready      : downstream accepts the held result
//   out_data/rdidx : the held result. It stays stable while out_valid & !out_ready.
module qpu_wbck_obuf #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [RW-1:0] in_rdidx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_rdidx
);

    // A capture can take the slot in the same cycle that the slot drains.
    // This is what allows one result per cycle back to back.
    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the payload is cleared as well as valid, so the outputs are at a known value after reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rdidx <= '0;
        end else if (in_valid && in_ready) begin
            // NOTE: non-blocking assignments, so every register samples the values from before this edge.
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_rdidx <= in_rdidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qpu_exu_longp_wbck_arb.sv
// qpu_exu_longp_wbck_arb: long-pipe write-back arbiter between the LSU and the MCU.
// Results retire strictly in OITF order. A source is granted only when its itag
// equals the itag of the oldest OITF entry.
//   lsu_wbck_i_* / mcu_wbck_i_* : source results (valid/ready, data, itag)
//   oitf_*                      : oldest-entry view of the OITF and its retire strobe
//   longp_wbck_o_*              : registered result towards the final write-back stage
//   wbck_pend_*                 : a retired result is still waiting for its RF write
//   err_o                       : sticky error. Set by a double itag match or by watchdog expiry.
module qpu_exu_longp_wbck_arb
    import qpu_exu_longp_wbck_arb_pkg::*;
#(
    parameter int XLEN      = QPU_XLEN,
    parameter int RFIDX_W   = QPU_RFIDX_W,
    parameter int ITAG_W    = QPU_ITAG_W,
    parameter int STALL_MAX = 255
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               lsu_wbck_i_valid,
    output logic               lsu_wbck_i_ready,
    input  logic [XLEN-1:0]    lsu_wbck_i_data,
    input  logic [ITAG_W-1:0]  lsu_wbck_i_itag,

    input  logic               mcu_wbck_i_valid,
    output logic               mcu_wbck_i_ready,
    input  logic [XLEN-1:0]    mcu_wbck_i_data,
    input  logic [ITAG_W-1:0]  mcu_wbck_i_itag,

    input  logic               oitf_empty,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic               oitf_ret_rdwen,
    output logic               oitf_ret_ena,

    output logic               longp_wbck_o_valid,
    input  logic               longp_wbck_o_ready,
    output logic [XLEN-1:0]    longp_wbck_o_data,
    output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,

    output logic               wbck_pend_vld,
    output logic [RFIDX_W-1:0] wbck_pend_rdidx,

    output logic               err_o
);

    localparam logic [WDOG_W-1:0] STALL_LIM = WDOG_W'(STALL_MAX);

    logic              lsu_hit;
    logic              mcu_hit;
    logic              grant;
    logic              buf_free;
    logic              accept;
    logic              capture;
    src_e              src_sel;
    logic [XLEN-1:0]   cap_data;
    logic              stall;
    logic [WDOG_W-1:0] stall_cnt;
    logic [WDOG_W-1:0] stall_cnt_nxt;

    assign lsu_hit = !oitf_empty & lsu_wbck_i_valid & (lsu_wbck_i_itag == oitf_ret_ptr);
    assign mcu_hit = !oitf_empty & mcu_wbck_i_valid & (mcu_wbck_i_itag == oitf_ret_ptr);
    assign grant   = lsu_hit | mcu_hit;

    // If both sources match, that is a protocol violation. The LSU still takes the slot.
    assign src_sel = lsu_hit ? SRC_LSU : SRC_MCU;

    // An entry that writes no register retires even when the output buffer is blocked.
    // No entry retires while reset is asserted.
    assign accept  = rst_n & grant & (oitf_ret_rdwen ? buf_free : 1'b1);
    assign capture = accept & oitf_ret_rdwen;

    assign oitf_ret_ena     = accept;
    assign lsu_wbck_i_ready = accept & (src_sel == SRC_LSU);
    assign mcu_wbck_i_ready = accept & (src_sel == SRC_MCU);

    assign cap_data = (src_sel == SRC_LSU) ? lsu_wbck_i_data : mcu_wbck_i_data;

    qpu_wbck_obuf #(
        .DW (XLEN),
        .RW (RFIDX_W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (capture),
        .in_ready  (buf_free),
        .in_data   (cap_data),
        .in_rdidx  (oitf_ret_rdidx),
        .out_valid (longp_wbck_o_valid),
        .out_ready (longp_wbck_o_ready),
        .out_data  (longp_wbck_o_data),
        .out_rdidx (longp_wbck_o_rdidx)
    );

    // The buffered entry has already retired from the OITF. Until it reaches the RF,
    // the dependency check must still see its destination.
    assign wbck_pend_vld   = longp_wbck_o_valid;
    assign wbck_pend_rdidx = longp_wbck_o_rdidx;

    // Watchdog. The counter counts cycles in which the OITF is non-empty and nothing retires.
    // It saturates at the limit.
    assign stall = !oitf_empty & !oitf_ret_ena;

    always_comb begin
        // NOTE: assign a default first, so that no path through this block can infer a latch.
        stall_cnt_nxt = '0;
        if (stall) begin
            stall_cnt_nxt = (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err_o     <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            // err_o sets on the edge where the counter reaches the limit. It is sticky.
            if ((lsu_hit & mcu_hit) || (stall_cnt_nxt == STALL_LIM)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qpu_exu_longp_wbck_arb.sv
// Self-checking bench for qpu_exu_longp_wbck_arb. It uses directed vectors and a scoreboard
// for the output stream. The watchdog limit is shortened to 4 cycles.
module tb_qpu_exu_longp_wbck_arb;

    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;
    localparam int ITAG_W  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               lsu_wbck_i_valid, lsu_wbck_i_ready;
    logic [XLEN-1:0]    lsu_wbck_i_data;
    logic [ITAG_W-1:0]  lsu_wbck_i_itag;
    logic               mcu_wbck_i_valid, mcu_wbck_i_ready;
    logic [XLEN-1:0]    mcu_wbck_i_data;
    logic [ITAG_W-1:0]  mcu_wbck_i_itag;
    logic               oitf_empty;
    logic [ITAG_W-1:0]  oitf_ret_ptr;
    logic [RFIDX_W-1:0] oitf_ret_rdidx;
    logic               oitf_ret_rdwen;
    logic               oitf_ret_ena;
    logic               longp_wbck_o_valid, longp_wbck_o_ready;
    logic [XLEN-1:0]    longp_wbck_o_data;
    logic [RFIDX_W-1:0] longp_wbck_o_rdidx;
    logic               wbck_pend_vld;
    logic [RFIDX_W-1:0] wbck_pend_rdidx;
    logic               err_o;

    typedef struct {
        logic [XLEN-1:0]    data;
        logic [RFIDX_W-1:0] rdidx;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    qpu_exu_longp_wbck_arb #(
        .XLEN(XLEN), .RFIDX_W(RFIDX_W), .ITAG_W(ITAG_W), .STALL_MAX(4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lsu_wbck_i_valid   (lsu_wbck_i_valid),
        .lsu_wbck_i_ready   (lsu_wbck_i_ready),
        .lsu_wbck_i_data    (lsu_wbck_i_data),
        .lsu_wbck_i_itag    (lsu_wbck_i_itag),
        .mcu_wbck_i_valid   (mcu_wbck_i_valid),
        .mcu_wbck_i_ready   (mcu_wbck_i_ready),
        .mcu_wbck_i_data    (mcu_wbck_i_data),
        .mcu_wbck_i_itag    (mcu_wbck_i_itag),
        .oitf_empty         (oitf_empty),
        .oitf_ret_ptr       (oitf_ret_ptr),
        .oitf_ret_rdidx     (oitf_ret_rdidx),
        .oitf_ret_rdwen     (oitf_ret_rdwen),
        .oitf_ret_ena       (oitf_ret_ena),
        .longp_wbck_o_valid (longp_wbck_o_valid),
        .longp_wbck_o_ready (longp_wbck_o_ready),
        .longp_wbck_o_data  (longp_wbck_o_data),
        .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
        .wbck_pend_vld      (wbck_pend_vld),
        .wbck_pend_rdidx    (wbck_pend_rdidx),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // The monitor runs at every negedge. A valid output must match the front of the scoreboard.
    // The front entry is popped only on the handshake, so a stalled output that changes is caught.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && longp_wbck_o_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_unexpected: got data 0x%0h rdidx %0d, expected no output",
                         longp_wbck_o_data, longp_wbck_o_rdidx);
            end else begin
                if (longp_wbck_o_data !== exp_q[0].data || longp_wbck_o_rdidx !== exp_q[0].rdidx ||
                    wbck_pend_vld !== 1'b1 || wbck_pend_rdidx !== exp_q[0].rdidx) begin
                    miscompares++;
                    $display("FAIL out_data: got data 0x%0h rdidx %0d pend %0b/%0d, expected 0x%0h rdidx %0d pend 1/%0d",
                             longp_wbck_o_data, longp_wbck_o_rdidx, wbck_pend_vld, wbck_pend_rdidx,
                             exp_q[0].data, exp_q[0].rdidx, exp_q[0].rdidx);
                end
                if (longp_wbck_o_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lsu_wbck_i_valid   = 1'b0;
        lsu_wbck_i_data    = '0;
        lsu_wbck_i_itag    = '0;
        mcu_wbck_i_valid   = 1'b0;
        mcu_wbck_i_data    = '0;
        mcu_wbck_i_itag    = '0;
        oitf_empty         = 1'b1;
        oitf_ret_ptr       = '0;
        oitf_ret_rdidx     = '0;
        oitf_ret_rdwen     = 1'b0;
        longp_wbck_o_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [XLEN-1:0] d, input logic [RFIDX_W-1:0] r);
        exp_t e;
        e.data  = d;
        e.rdidx = r;
        exp_q.push_back(e);
    endtask

    task automatic set_oitf(input logic [ITAG_W-1:0] ptr, input logic [RFIDX_W-1:0] rd, input logic wen);
        oitf_empty     = 1'b0;
        oitf_ret_ptr   = ptr;
        oitf_ret_rdidx = rd;
        oitf_ret_rdwen = wen;
    endtask

    task automatic drive_lsu(input logic v, input logic [ITAG_W-1:0] tag, input logic [XLEN-1:0] d);
        lsu_wbck_i_valid = v;
        lsu_wbck_i_itag  = tag;
        lsu_wbck_i_data  = d;
    endtask

    task automatic drive_mcu(input logic v, input logic [ITAG_W-1:0] tag, input logic [XLEN-1:0] d);
        mcu_wbck_i_valid = v;
        mcu_wbck_i_itag  = tag;
        mcu_wbck_i_data  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected $finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_valid", longp_wbck_o_valid, 0);
        check("rst_pend", wbck_pend_vld, 0);
        check("rst_err", err_o, 0);
        check("rst_data", longp_wbck_o_data, 0);
        check("rst_rdidx", longp_wbck_o_rdidx, 0);

        // Test 1: LSU hit and capture. The result appears one cycle later and pend lasts one cycle.
        tick();
        set_oitf(2'd1, 5'd7, 1'b1);
        drive_lsu(1'b1, 2'd1, 32'hA5A5_0001);
        push(32'hA5A5_0001, 5'd7);
        @(negedge clk);
        check("t1_lsu_ready", lsu_wbck_i_ready, 1);
        check("t1_ret_ena", oitf_ret_ena, 1);
        check("t1_valid_N", longp_wbck_o_valid, 0);
        tick();
        idle();
        @(negedge clk);
        check("t1_valid_N1", longp_wbck_o_valid, 1);
        check("t1_pend_N1", wbck_pend_vld, 1);
        tick();
        @(negedge clk);
        check("t1_pend_N2", wbck_pend_vld, 0);

        // Test 2: the MCU itag does not match and it waits. It is granted once ptr reaches its itag.
        tick();
        set_oitf(2'd1, 5'd9, 1'b1);
        drive_mcu(1'b1, 2'd2, 32'h0000_00C3);
        @(negedge clk);
        check("t2_mcu_wait", mcu_wbck_i_ready, 0);
        check("t2_no_ret", oitf_ret_ena, 0);
        check("t2_lsu_ready", lsu_wbck_i_ready, 0);
        tick();
        oitf_ret_ptr = 2'd2;
        push(32'h0000_00C3, 5'd9);
        @(negedge clk);
        check("t2_mcu_grant", mcu_wbck_i_ready, 1);
        check("t2_ret", oitf_ret_ena, 1);
        tick();
        idle();
        tick();

        // Test 3: the output is stalled and a new hit is held off. When ready rises, drain and capture happen in the same cycle.
        longp_wbck_o_ready = 1'b0;
        set_oitf(2'd3, 5'd3, 1'b1);
        drive_lsu(1'b1, 2'd3, 32'h1111_0003);
        push(32'h1111_0003, 5'd3);
        tick();
        set_oitf(2'd0, 5'd4, 1'b1);
        drive_lsu(1'b1, 2'd0, 32'h2222_0004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_lsu_blocked", lsu_wbck_i_ready, 0);
            check("t3_no_ret", oitf_ret_ena, 0);
            tick();
        end
        longp_wbck_o_ready = 1'b1;
        push(32'h2222_0004, 5'd4);
        @(negedge clk);
        check("t3_lsu_accept", lsu_wbck_i_ready, 1);
        check("t3_ret", oitf_ret_ena, 1);
        tick();
        idle();
        @(negedge clk);
        check("t3_valid_kept", longp_wbck_o_valid, 1);
        tick();
        @(negedge clk);
        check("t3_drained", longp_wbck_o_valid, 0);

        // Test 4: an entry with rdwen=0 retires even while the buffer is full and stalled.
        tick();
        longp_wbck_o_ready = 1'b0;
        set_oitf(2'd1, 5'd12, 1'b1);
        drive_lsu(1'b1, 2'd1, 32'h3333_000C);
        push(32'h3333_000C, 5'd12);
        tick();
        drive_lsu(1'b0, 2'd0, 32'h0);
        set_oitf(2'd2, 5'd13, 1'b0);
        drive_mcu(1'b1, 2'd2, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t4_mcu_ready", mcu_wbck_i_ready, 1);
        check("t4_ret", oitf_ret_ena, 1);
        tick();
        idle();
        longp_wbck_o_ready = 1'b0;
        @(negedge clk);
        check("t4_buf_kept", longp_wbck_o_valid, 1);
        tick();
        longp_wbck_o_ready = 1'b1;
        tick();

        // Test 5: both sources match. The LSU wins and err_o sets and stays set.
        do_reset();
        set_oitf(2'd0, 5'd2, 1'b1);
        drive_lsu(1'b1, 2'd0, 32'h4444_0002);
        drive_mcu(1'b1, 2'd0, 32'h5555_0002);
        push(32'h4444_0002, 5'd2);
        @(negedge clk);
        check("t5_lsu_ready", lsu_wbck_i_ready, 1);
        check("t5_mcu_ready", mcu_wbck_i_ready, 0);
        check("t5_ret", oitf_ret_ena, 1);
        check("t5_err_before", err_o, 0);
        tick();
        idle();
        @(negedge clk);
        check("t5_err_set", err_o, 1);
        tick();
        @(negedge clk);
        check("t5_err_sticky", err_o, 1);

        // Test 6: the watchdog fires after 4 stalled cycles. A reset pulse then clears err_o and the buffer.
        do_reset();
        longp_wbck_o_ready = 1'b0;
        set_oitf(2'd3, 5'd21, 1'b1);
        drive_lsu(1'b1, 2'd3, 32'h6666_0015);
        push(32'h6666_0015, 5'd21);
        tick();
        drive_lsu(1'b0, 2'd0, 32'h0);
        set_oitf(2'd0, 5'd22, 1'b1);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("t6_err_3cyc", err_o, 0);
        tick();
        @(negedge clk);
        check("t6_err_4cyc", err_o, 1);
        // Reset cycle: a hit that would otherwise retire is present, but no retire may be issued.
        rst_n = 1'b0;
        set_oitf(2'd1, 5'd23, 1'b0);
        drive_lsu(1'b1, 2'd1, 32'h7777_0017);
        @(negedge clk);
        check("t6_no_ret_in_rst", oitf_ret_ena, 0);
        check("t6_no_ready_in_rst", lsu_wbck_i_ready, 0);
        tick();
        exp_q.delete();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_err_clr", err_o, 0);
        check("t6_valid_clr", longp_wbck_o_valid, 0);
        check("t6_pend_clr", wbck_pend_vld, 0);
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
